ahb3lite_sram_1rw: RTL and testbench
====================================

// Module: ahb3lite_sram_1rw
// PURPOSE
//  AHB3-Lite slave wrapping one on-chip SRAM (register array), little-endian, zero wait states.
//  Sits on the AHB3-Lite bus behind the decoder; serves byte/halfword/word reads and writes.
//  Always answers OKAY; burst and protection attributes are accepted and ignored.
// PARAMETERS
//  MEM_SIZE    0    memory size in bytes; 0 = use MEM_DEPTH
//  MEM_DEPTH   256  memory depth in HDATA_SIZE words (used when MEM_SIZE==0)
//  HADDR_SIZE  32   address bus width
//  HDATA_SIZE  32   data bus width (32 required; byte lanes = HDATA_SIZE/8)
// PORTS
//  HCLK       in   1           clock, all logic on rising edge
//  HRESETn    in   1           reset, synchronous, active-low
//  HSEL       in   1           slave select
//  HADDR      in   HADDR_SIZE  byte address
//  HWDATA     in   HDATA_SIZE  write data (data phase)
//  HRDATA     out  HDATA_SIZE  read data (data phase)
//  HWRITE     in   1           1=write, 0=read
//  HSIZE      in   3           0=byte,1=halfword,2=word; >=2 treated as word
//  HBURST     in   3           ignored
//  HPROT      in   4           ignored
//  HTRANS     in   2           0=IDLE,1=BUSY,2=NONSEQ,3=SEQ
//  HREADYOUT  out  1           slave ready
//  HREADY     in   1           bus ready (mux of all HREADYOUT)
//  HRESP      out  1           0=OKAY (constant)
// BEHAVIOUR
//  - Depth D = MEM_SIZE ? MEM_SIZE/(HDATA_SIZE/8) : MEM_DEPTH; word index = HADDR[clog2(D)+1:2], wraps modulo D.
//  - Reset (HRESETn=0 at edge): HREADYOUT=1, HRESP=0, HRDATA=0, data-phase regs cleared, all memory words=0.
//  - Address phase accepted at edge when HSEL & HREADY & HTRANS[1]; latch addr, HWRITE, byte enables.
//  - IDLE/BUSY, HSEL=0 or HREADY=0: no access, no state change, OKAY.
//  - Byte enables: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0}+{0,1} (HADDR[0] ignored); word -> all 4.
//  - Write: HWDATA sampled at the edge ending the data phase; only enabled lanes updated.
//  - Read: array read with address-phase index; HRDATA valid throughout data phase (1-cycle latency),
//    full word returned regardless of HSIZE; HRDATA holds last read value otherwise.
//  - Read address phase coinciding with a write data phase to same word: forwarding merges the new
//    write bytes; read returns post-write data. Different word: no interaction.
//  - HREADYOUT constant 1 after reset (no wait states); HRESP constant 0.
//  - Back-to-back NONSEQ/SEQ transfers fully pipelined, one per cycle.
//  - Reset mid-transfer: pending write discarded, memory cleared, HRDATA=0 next cycle.
// STRUCTURE
//  - Package ahb3lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_B8/B16/B32, HRESP_OKAY/ERROR.
//  - Sub-module sram_1rw_be: D x HDATA_SIZE array, sync write w/ byte enables, registered read, sync clear.
//  - Top: address-phase capture, byte-enable decode, write forwarding, output drive.
// TESTING
//  - Reset then read 0x10 (word) -> HRDATA=0x00000000, HRESP=0, HREADYOUT=1.
//  - Word write 0x04<=0xDEADBEEF, then read 0x04 -> 0xDEADBEEF next data phase.
//  - Byte writes 0x20<=0x11, 0x21<=0x22, 0x22<=0x33, 0x23<=0x44 (data on lane) -> word read 0x20 = 0x44332211.
//  - Halfword write 0x32<=0xABCD0000 onto 0x30 holding 0x12345678 -> read 0x30 = 0xABCD5678.
//  - Write 0x40<=0xCAFEF00D immediately followed by read 0x40 (SEQ) -> 0xCAFEF00D, no wait state.
//  - IDLE, BUSY, HSEL=0 and HREADY=0 write attempts to 0x50 -> read 0x50 still 0; address 0x400 aliases 0x000 (D=256).

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the byte-lane decode used by the SRAM slave.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane enables on a 32-bit bus; sizes above word collapse to word.
  function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_B8:  be = 4'b0001 << addr_lo;
      HSIZE_B16: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word array with byte-enable writes, registered read with
// caller-supplied byte forwarding, and synchronous clear of all contents.
module sram_1rw_be #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  input  logic [DW/8-1:0] fwd_be,
  input  logic [DW-1:0]   fwd_data,
  output logic [DW-1:0]   rdata
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] wr_word_d;
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Merge enabled write lanes into the stored word; merge forwarded lanes into the read word.
  always_comb begin
    wr_word_d = mem_q[waddr];
    rdata_d   = rdata_q;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) wr_word_d[8*b +: 8] = wdata[8*b +: 8];
    end
    if (re) begin
      rdata_d = mem_q[raddr];
      for (int b = 0; b < NB; b++) begin
        if (fwd_be[b]) rdata_d[8*b +: 8] = fwd_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) mem_q[waddr] <= wr_word_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_1rw.sv
// AHB3-Lite zero-wait-state slave in front of a byte-writable on-chip SRAM.
module ahb3lite_sram_1rw
  import ahb3lite_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 0,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP
);

  localparam int unsigned NB    = HDATA_SIZE / 8;
  localparam int unsigned DEPTH = (MEM_SIZE != 0) ? MEM_SIZE / NB : MEM_DEPTH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          acc_c;
  logic [AW-1:0] addr_idx_c;
  logic [NB-1:0] addr_be_c;
  logic          mem_we_c;
  logic          mem_re_c;
  logic [NB-1:0] fwd_be_c;

  logic          dp_write_d, dp_write_q;
  logic [NB-1:0] dp_be_d,    dp_be_q;
  logic [AW-1:0] dp_idx_d,   dp_idx_q;
  logic          hreadyout_d, hreadyout_q;
  logic          hresp_d,     hresp_q;

  // Burst/protection attributes and high address bits carry no meaning here.
  logic unused_c;
  assign unused_c = ^{HBURST, HPROT, HADDR, HTRANS[0]};

  assign acc_c      = HSEL & HREADY & HTRANS[1];
  assign addr_idx_c = HADDR[AW+1:2];
  assign addr_be_c  = NB'(be_decode(HSIZE, HADDR[1:0]));

  // Data-phase state advances only when the bus moves on.
  always_comb begin
    dp_write_d  = dp_write_q;
    dp_be_d     = dp_be_q;
    dp_idx_d    = dp_idx_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    if (HREADY) begin
      dp_write_d = acc_c & HWRITE;
      dp_be_d    = (acc_c & HWRITE) ? addr_be_c : '0;
      dp_idx_d   = acc_c ? addr_idx_c : dp_idx_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_write_q  <= 1'b0;
      dp_be_q     <= '0;
      dp_idx_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      dp_write_q  <= dp_write_d;
      dp_be_q     <= dp_be_d;
      dp_idx_q    <= dp_idx_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // A read hitting the word being written this cycle sees the new bytes.
  assign mem_we_c = dp_write_q & HREADY;
  assign mem_re_c = acc_c & ~HWRITE;
  assign fwd_be_c = (mem_we_c && (dp_idx_q == addr_idx_c)) ? dp_be_q : '0;

  sram_1rw_be #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (HDATA_SIZE)
  ) u_sram (
    .clk      (HCLK),
    .clr      (~HRESETn),
    .we       (mem_we_c),
    .be       (dp_be_q),
    .waddr    (dp_idx_q),
    .wdata    (HWDATA),
    .re       (mem_re_c),
    .raddr    (addr_idx_c),
    .fwd_be   (fwd_be_c),
    .fwd_data (HWDATA),
    .rdata    (HRDATA)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_1rw.sv
// Directed bench for the AHB3-Lite SRAM slave: reset, sizes, forwarding, ignored cycles, aliasing.
module tb_ahb3lite_sram_1rw;

  logic        HRESETn;
  logic        HCLK;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADYOUT;
  logic        HREADY;
  logic        HRESP;

  int errors = 0;
  int checks = 0;

  ahb3lite_sram_1rw dut (
    .HRESETn   (HRESETn),
    .HCLK      (HCLK),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HREADYOUT (HREADYOUT),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One bus cycle: present inputs, take the rising edge, settle 1 time unit past it.
  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rdy);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = wdata;
    HREADY = rdy;
    HBURST = 3'b001;
    HPROT  = 4'b0011;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    drive(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, wdata, 1'b1);
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    idle(32'h0);
    idle(32'h0);
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b exp 1", HREADYOUT); end
    checks++;
    if (HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b exp 0", HRESP); end
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h exp 00000000", HRDATA); end
    HRESETn = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL read_0x10 got %h exp 00000000", HRDATA); end
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++; $display("FAIL read_0x10_resp got rdy=%b resp=%b exp rdy=1 resp=0", HREADYOUT, HRESP);
    end
    idle(32'h0);
  endtask

  task automatic test_word;
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h04, 32'h0, 1'b1);
    idle(32'hDEADBEEF);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rw got %h exp deadbeef", HRDATA); end
    idle(32'h0);
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL hrdata_hold got %h exp deadbeef", HRDATA); end
  endtask

  task automatic test_bytes;
    drive(1'b1, 2'b10, 1'b1, 3'b000, 32'h20, 32'h0, 1'b1);
    drive(1'b1, 2'b11, 1'b1, 3'b000, 32'h21, 32'h00000011, 1'b1);
    drive(1'b1, 2'b11, 1'b1, 3'b000, 32'h22, 32'h00002200, 1'b1);
    drive(1'b1, 2'b11, 1'b1, 3'b000, 32'h23, 32'h00330000, 1'b1);
    idle(32'h44000000);
    drive(1'b1, 2'b10, 1'b0, 3'b000, 32'h20, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h44332211) begin errors++; $display("FAIL byte_lanes got %h exp 44332211", HRDATA); end
    idle(32'h0);
  endtask

  task automatic test_halfword;
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h30, 32'h0, 1'b1);
    drive(1'b1, 2'b10, 1'b1, 3'b001, 32'h32, 32'h12345678, 1'b1);
    idle(32'hABCD0000);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'hABCD5678) begin errors++; $display("FAIL halfword_upper got %h exp abcd5678", HRDATA); end
    drive(1'b1, 2'b10, 1'b1, 3'b001, 32'h31, 32'h0, 1'b1);
    idle(32'h9999EEFF);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'hABCDEEFF) begin errors++; $display("FAIL halfword_odd_addr got %h exp abcdeeff", HRDATA); end
    idle(32'h0);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h40, 32'h0, 1'b1);
    drive(1'b1, 2'b11, 1'b0, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1);
    checks++;
    if (HRDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL fwd_same_word got %h exp cafef00d", HRDATA); end
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL fwd_no_wait got %b exp 1", HREADYOUT); end
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h44, 32'h0, 1'b1);
    drive(1'b1, 2'b11, 1'b0, 3'b010, 32'h40, 32'h11112222, 1'b1);
    checks++;
    if (HRDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL fwd_other_word got %h exp cafef00d", HRDATA); end
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h44, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h11112222) begin errors++; $display("FAIL b2b_second_write got %h exp 11112222", HRDATA); end
    idle(32'h0);
  endtask

  task automatic test_ignored;
    drive(1'b1, 2'b00, 1'b1, 3'b010, 32'h50, 32'h0, 1'b1);
    idle(32'hFFFFFFFF);
    drive(1'b1, 2'b01, 1'b1, 3'b010, 32'h50, 32'h0, 1'b1);
    idle(32'hFFFFFFFF);
    drive(1'b0, 2'b10, 1'b1, 3'b010, 32'h50, 32'h0, 1'b1);
    idle(32'hFFFFFFFF);
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h50, 32'h0, 1'b0);
    idle(32'hFFFFFFFF);
    checks++;
    if (HRESP !== 1'b0) begin errors++; $display("FAIL ignored_hresp got %b exp 0", HRESP); end
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h50, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL ignored_writes got %h exp 00000000", HRDATA); end
    idle(32'h0);
  endtask

  task automatic test_alias;
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h400, 32'h0, 1'b1);
    idle(32'h5A5A5A5A);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h000, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h5A5A5A5A) begin errors++; $display("FAIL alias_0x400 got %h exp 5a5a5a5a", HRDATA); end
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h404, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_0x404 got %h exp deadbeef", HRDATA); end
    idle(32'h0);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h60, 32'h0, 1'b1);
    HRESETn = 1'b0;
    idle(32'h77777777);
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL midreset_hrdata got %h exp 00000000", HRDATA); end
    HRESETn = 1'b1;
    idle(32'h88888888);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h60, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL midreset_discard got %h exp 00000000", HRDATA); end
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1);
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL midreset_cleared got %h exp 00000000", HRDATA); end
    idle(32'h0);
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HBURST = '0; HPROT = '0; HTRANS = 2'b00; HREADY = 1'b1;
    test_reset();
    test_word();
    test_bytes();
    test_halfword();
    test_back_to_back();
    test_ignored();
    test_alias();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
